regfile_wb_sched: RTL and testbench

Write-back scheduler and scoreboard for the 32-entry register file.
- Shares the register file's single write port between three producers: ALU (single-cycle), load unit (mem) and mult/div unit (md).
- Tracks destinations of issued long-latency ops and exposes per-operand busy flags so the decode stage can stall on RAW hazards.
- Drives rd_num/rd_data/rd_we of the register file from registered outputs.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 45 ++++
 rtl/regfile_wb_sched.sv | 128 ++++++++++++
 tb/tb_regfile_wb_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-back path.
package regfile_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM,
    SRC_MD
  } wb_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; after reset requester 0 is favoured.
module rr_arb2 (
  input  logic clk,
  input  logic rst_b,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // ptr_reg == 0 favours req0 when both request.
  logic ptr_reg;
  logic ptr_next;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && (!req1 || !ptr_reg)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (gnt0) begin
      ptr_next = 1'b1;
    end else if (gnt1) begin
      ptr_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: shares the register-file write port between ALU, load
// and mult/div, and keeps a pending-destination scoreboard for RAW stalls.
module regfile_wb_sched #(
  parameter int XLEN = regfile_pkg::XLEN,
  parameter int NREG = regfile_pkg::NREG
) (
  input  logic                           clk,
  input  logic                           rst_b,
  input  logic                           alu_valid,
  input  logic [regfile_pkg::REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]                alu_data,
  input  logic                           mem_valid,
  output logic                           mem_ready,
  input  logic [regfile_pkg::REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]                mem_data,
  input  logic                           md_valid,
  output logic                           md_ready,
  input  logic [regfile_pkg::REG_AW-1:0] md_rd,
  input  logic [XLEN-1:0]                md_data,
  input  logic                           issue_valid,
  input  logic [regfile_pkg::REG_AW-1:0] issue_rd,
  input  logic [regfile_pkg::REG_AW-1:0] rs_num,
  input  logic [regfile_pkg::REG_AW-1:0] rt_num,
  output logic                           rs_busy,
  output logic                           rt_busy,
  output logic [regfile_pkg::REG_AW-1:0] rd_num,
  output logic [XLEN-1:0]                rd_data,
  output logic                           rd_we,
  output logic                           idle
);

  import regfile_pkg::*;

  logic              gnt_mem;
  logic              gnt_md;
  wb_src_e           src;
  logic [REG_AW-1:0] sel_rd;
  logic [XLEN-1:0]   sel_data;

  logic              rd_we_reg,   rd_we_next;
  logic [REG_AW-1:0] rd_num_reg,  rd_num_next;
  logic [XLEN-1:0]   rd_data_reg, rd_data_next;
  logic [NREG-1:0]   pend_reg,    pend_next;

  // The ALU is never back-pressured, so it simply masks the mem/md arbiter.
  rr_arb2 u_arb (
    .clk   (clk),
    .rst_b (rst_b),
    .en    (!alu_valid),
    .req0  (mem_valid),
    .req1  (md_valid),
    .gnt0  (gnt_mem),
    .gnt1  (gnt_md)
  );

  assign mem_ready = gnt_mem;
  assign md_ready  = gnt_md;

  always_comb begin
    src = SRC_NONE;
    if (alu_valid) begin
      src = SRC_ALU;
    end else if (gnt_mem) begin
      src = SRC_MEM;
    end else if (gnt_md) begin
      src = SRC_MD;
    end
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    case (src)
      SRC_ALU: begin sel_rd = alu_rd; sel_data = alu_data; end
      SRC_MEM: begin sel_rd = mem_rd; sel_data = mem_data; end
      SRC_MD:  begin sel_rd = md_rd;  sel_data = md_data;  end
      default: ;
    endcase
  end

  // r0 writes complete the handshake but never assert the write enable.
  assign rd_we_next   = (src != SRC_NONE) && (sel_rd != '0);
  assign rd_num_next  = (src != SRC_NONE) ? sel_rd   : rd_num_reg;
  assign rd_data_next = (src != SRC_NONE) ? sel_data : rd_data_reg;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
      if (gi == 0) begin : g_r0
        assign pend_next[gi] = 1'b0;
      end else begin : g_rn
        logic set_hit;
        logic clr_hit;
        assign set_hit = issue_valid && (issue_rd == REG_AW'(gi));
        assign clr_hit = (gnt_mem && (mem_rd == REG_AW'(gi))) ||
                         (gnt_md  && (md_rd  == REG_AW'(gi)));
        // A same-cycle issue is newer than the retiring write, so it wins.
        assign pend_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : pend_reg[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_we_reg   <= 1'b0;
      rd_num_reg  <= '0;
      rd_data_reg <= '0;
      pend_reg    <= '0;
    end else begin
      rd_we_reg   <= rd_we_next;
      rd_num_reg  <= rd_num_next;
      rd_data_reg <= rd_data_next;
      pend_reg    <= pend_next;
    end
  end

  assign rd_we   = rd_we_reg;
  assign rd_num  = rd_num_reg;
  assign rd_data = rd_data_reg;

  // The in-flight term covers the cycle before the write lands in the file.
  assign rs_busy = (rs_num != '0) &&
                   (pend_reg[rs_num] || (rd_we_reg && (rd_num_reg == rs_num)));
  assign rt_busy = (rt_num != '0) &&
                   (pend_reg[rt_num] || (rd_we_reg && (rd_num_reg == rt_num)));

  assign idle = (pend_reg == '0) && !rd_we_reg;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: vector table with a write scoreboard, plus
// hand-written round-robin and asynchronous-reset sequences.
module tb_regfile_wb_sched;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        alu_valid, mem_valid, md_valid, issue_valid;
  logic [4:0]  alu_rd, mem_rd, md_rd, issue_rd, rs_num, rt_num;
  logic [31:0] alu_data, mem_data, md_data;
  logic        mem_ready, md_ready, rs_busy, rt_busy, rd_we, idle;
  logic [4:0]  rd_num;
  logic [31:0] rd_data;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regfile_wb_sched dut (
    .clk(clk), .rst_b(rst_b),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs_num(rs_num), .rt_num(rt_num), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .rd_num(rd_num), .rd_data(rd_data), .rd_we(rd_we), .idle(idle)
  );

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] adat;
    logic mv; logic [4:0] mrd; logic [31:0] mdat;
    logic dv; logic [4:0] drd; logic [31:0] ddat;
    logic iv; logic [4:0] ird;
    logic [4:0] rs; logic [4:0] rt;
    logic emr; logic edr; logic ers; logic ert; logic eidle;
  } vec_t;

  vec_t    vecs[$];
  wb_req_t sb[$];

  function automatic vec_t mk(
      input logic av, input logic [4:0] ard, input logic [31:0] adat,
      input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
      input logic dv, input logic [4:0] drd, input logic [31:0] ddat,
      input logic iv, input logic [4:0] ird,
      input logic [4:0] rs, input logic [4:0] rt,
      input logic emr, input logic edr, input logic ers, input logic ert,
      input logic eidle);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat;
    v.mv = mv; v.mrd = mrd; v.mdat = mdat;
    v.dv = dv; v.drd = drd; v.ddat = ddat;
    v.iv = iv; v.ird = ird; v.rs = rs; v.rt = rt;
    v.emr = emr; v.edr = edr; v.ers = ers; v.ert = ert; v.eidle = eidle;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    md_valid = 0; md_rd = 0; md_data = 0;
    issue_valid = 0; issue_rd = 0; rs_num = 0; rt_num = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_b = 0;
    @(posedge clk); #1;
    rst_b = 1;
  endtask

  initial begin
    vec_t    v;
    wb_req_t e;
    wb_req_t got;
    int      mem_n;
    int      md_n;
    logic    exp_mem;

    //        av ard adat          mv mrd mdat      dv drd ddat      iv ird rs rt emr edr ers ert idle
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0, 0,        0, 0, 5, 0,  0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0, 5, 5,  0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 3, 32'h33,       1, 7, 32'h11,   0, 0, 0,        0, 0, 3, 7,  0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,            1, 7, 32'h11,   0, 0, 0,        0, 0, 3, 7,  1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0, 7, 3,  0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 10, 32'hA0,  1, 11, 32'hB0,  0, 0, 10, 11, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,            1, 10, 32'hA0,  1, 12, 32'hB1,  0, 0, 10, 11, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,            1, 13, 32'hA1,  1, 12, 32'hB1,  0, 0, 10, 12, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 32'h1,        1, 13, 32'hA1,  0, 0, 0,        0, 0, 12, 13, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 13, 32'hA1,  0, 0, 0,        0, 0, 1, 13, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,        1, 8, 8, 13, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0, 8, 0,  0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 8, 32'h88,   0, 0, 0,        0, 0, 8, 8,  1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0, 8, 8,  0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0, 8, 8,  0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 32'h55,       0, 0, 0,        0, 0, 0,        1, 0, 0, 0,  0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0, 0, 0,  0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,            1, 9, 32'h99,   0, 0, 0,        1, 9, 9, 0,  1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0, 9, 0,  0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        1, 9, 32'h9A,   0, 0, 9, 0,  0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0, 9, 0,  0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 0, 32'h77,   0, 0, 0,        0, 0, 9, 0,  1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,        0, 0, 0,        0, 0, 0, 0,  0, 0, 0, 0, 1));

    clear_inputs();
    rst_b = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_we", {31'd0, rd_we}, 32'd0);
    chk("reset rd_num", {27'd0, rd_num}, 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset idle", {31'd0, idle}, 32'd1);
    rst_b = 1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
      mem_valid = v.mv; mem_rd = v.mrd; mem_data = v.mdat;
      md_valid = v.dv; md_rd = v.drd; md_data = v.ddat;
      issue_valid = v.iv; issue_rd = v.ird; rs_num = v.rs; rt_num = v.rt;
      #1;
      chk($sformatf("v%0d mem_ready", i), {31'd0, mem_ready}, {31'd0, v.emr});
      chk($sformatf("v%0d md_ready", i), {31'd0, md_ready}, {31'd0, v.edr});
      chk($sformatf("v%0d rs_busy", i), {31'd0, rs_busy}, {31'd0, v.ers});
      chk($sformatf("v%0d rt_busy", i), {31'd0, rt_busy}, {31'd0, v.ert});
      chk($sformatf("v%0d idle", i), {31'd0, idle}, {31'd0, v.eidle});
      e.valid = 1'b0; e.rd = '0; e.data = '0;
      if (v.av)       begin e.valid = (v.ard != 0); e.rd = v.ard; e.data = v.adat; end
      else if (v.emr) begin e.valid = (v.mrd != 0); e.rd = v.mrd; e.data = v.mdat; end
      else if (v.edr) begin e.valid = (v.drd != 0); e.rd = v.drd; e.data = v.ddat; end
      sb.push_back(e);
      @(posedge clk); #1;
      got = sb.pop_front();
      chk($sformatf("v%0d rd_we", i), {31'd0, rd_we}, {31'd0, got.valid});
      if (got.valid) begin
        chk($sformatf("v%0d rd_num", i), {27'd0, rd_num}, {27'd0, got.rd});
        chk($sformatf("v%0d rd_data", i), rd_data, got.data);
      end
      $display("vec %0d: we=%0d num=%0d data=0x%0h busy=%0d/%0d idle=%0d",
               i, rd_we, rd_num, rd_data, rs_busy, rt_busy, idle);
    end

    // Round-robin from reset with both long-latency producers always valid.
    do_reset();
    mem_n = 0; md_n = 0;
    mem_valid = 1; mem_rd = 20; mem_data = 32'hA000;
    md_valid = 1;  md_rd = 21;  md_data = 32'hB000;
    for (int g = 0; g < 4; g++) begin
      #1;
      exp_mem = (g % 2 == 0);
      chk($sformatf("rr%0d mem_ready", g), {31'd0, mem_ready}, {31'd0, exp_mem});
      chk($sformatf("rr%0d md_ready", g), {31'd0, md_ready}, {31'd0, !exp_mem});
      chk($sformatf("rr%0d both_ready", g), {31'd0, mem_ready & md_ready}, 32'd0);
      @(posedge clk); #1;
      chk($sformatf("rr%0d rd_num", g), {27'd0, rd_num}, exp_mem ? 32'd20 : 32'd21);
      chk($sformatf("rr%0d rd_data", g), rd_data,
          exp_mem ? 32'hA000 + 32'(mem_n) : 32'hB000 + 32'(md_n));
      if (exp_mem) begin mem_n++; mem_data = 32'hA000 + 32'(mem_n); end
      else         begin md_n++;  md_data  = 32'hB000 + 32'(md_n);  end
      $display("rr %0d: granted %s num=%0d data=0x%0h", g, exp_mem ? "mem" : "md", rd_num, rd_data);
    end

    // Asynchronous reset with pending destinations and a write in flight.
    do_reset();
    issue_valid = 1; issue_rd = 8;
    @(posedge clk); #1;
    issue_rd = 9;
    @(posedge clk); #1;
    issue_valid = 0;
    alu_valid = 1; alu_rd = 4; alu_data = 32'h44;
    rs_num = 8; rt_num = 9;
    @(posedge clk); #1;
    alu_valid = 0;
    chk("pre_rst rd_we", {31'd0, rd_we}, 32'd1);
    chk("pre_rst rs_busy", {31'd0, rs_busy}, 32'd1);
    chk("pre_rst rt_busy", {31'd0, rt_busy}, 32'd1);
    chk("pre_rst idle", {31'd0, idle}, 32'd0);
    #2;
    rst_b = 0;
    #1;
    chk("async rd_we", {31'd0, rd_we}, 32'd0);
    chk("async rd_num", {27'd0, rd_num}, 32'd0);
    chk("async rs_busy", {31'd0, rs_busy}, 32'd0);
    chk("async rt_busy", {31'd0, rt_busy}, 32'd0);
    chk("async idle", {31'd0, idle}, 32'd1);
    @(posedge clk); #1;
    rst_b = 1;
    @(posedge clk); #1;
    chk("post_rst idle", {31'd0, idle}, 32'd1);
    chk("post_rst rs_busy", {31'd0, rs_busy}, 32'd0);
    $display("async reset: we=%0d busy=%0d/%0d idle=%0d", rd_we, rs_busy, rt_busy, idle);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
